// File: rtl/ar_fifo_drain_pkg.sv
// Shared constants for the acquisition FIFO read side: state encodings,
// default burst length and the word/halfword widths used by writer and reader.
package ar_fifo_drain_pkg;

  localparam int AR_BURST_LEN = 8;
  localparam int AR_OUT_W     = 16;
  localparam int AR_DATA_W    = 2 * AR_OUT_W;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RD   = 3'd1;
  localparam logic [2:0] ST_WT   = 3'd2;
  localparam logic [2:0] ST_HI   = 3'd3;
  localparam logic [2:0] ST_LO   = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE = ST_IDLE,
    S_RD   = ST_RD,
    S_WT   = ST_WT,
    S_HI   = ST_HI,
    S_LO   = ST_LO
  } state_e;

endpackage

// File: rtl/ar_fifo_drain.sv
// Burst reader: on FIFO full (or flush with data present) pops BURST_LEN words
// from a non-show-ahead FIFO and streams each as two halfwords, high half first.
module ar_fifo_drain #(
  parameter int BURST_LEN = ar_fifo_drain_pkg::AR_BURST_LEN,
  parameter int DATA_W    = ar_fifo_drain_pkg::AR_DATA_W,
  parameter int OUT_W     = ar_fifo_drain_pkg::AR_OUT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              full_ar,
  input  logic              empty_ar,
  input  logic [DATA_W-1:0] data_ar,
  output logic              rdreq_ar,
  input  logic              flush,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              underrun,
  output logic [2:0]        o_dbg_state
);
  import ar_fifo_drain_pkg::*;

  localparam logic [7:0] LAST_CNT = 8'(BURST_LEN - 1);

  state_e             r_state;
  logic [7:0]         r_word_cnt;
  logic [OUT_W-1:0]   r_hold;
  logic               r_rdreq;
  logic [OUT_W-1:0]   r_out_data;
  logic               r_out_valid;
  logic               r_out_last;
  logic               r_underrun;

  state_e             w_state_nxt;
  logic [7:0]         w_word_cnt_nxt;
  logic [OUT_W-1:0]   w_hold_nxt;
  logic               w_rdreq_nxt;
  logic [OUT_W-1:0]   w_out_data_nxt;
  logic               w_out_valid_nxt;
  logic               w_out_last_nxt;
  logic               w_underrun_nxt;
  logic               w_hs;
  logic               w_last_word;
  logic               w_trigger;

  // Stream handshake: a halfword transfers on a rising edge where out_valid and
  // out_ready are both high; out_data/out_last hold and out_valid stays high
  // until that happens.
  always_comb begin
    w_state_nxt     = r_state;
    w_word_cnt_nxt  = r_word_cnt;
    w_hold_nxt      = r_hold;
    w_rdreq_nxt     = 1'b0;
    w_out_data_nxt  = r_out_data;
    w_out_valid_nxt = r_out_valid;
    w_out_last_nxt  = r_out_last;
    w_underrun_nxt  = r_underrun;
    w_hs            = r_out_valid && out_ready;
    w_last_word     = (r_word_cnt == LAST_CNT);
    w_trigger       = full_ar || (flush && !empty_ar);

    case (r_state)
      S_IDLE: begin
        if (w_trigger) begin
          w_rdreq_nxt    = 1'b1;
          w_word_cnt_nxt = 8'd0;
          w_state_nxt    = S_RD;
        end
      end
      S_RD: begin
        w_state_nxt = S_WT;
      end
      S_WT: begin
        // Only the low half is needed after this cycle.
        w_hold_nxt      = data_ar[OUT_W-1:0];
        w_out_data_nxt  = data_ar[OUT_W +: OUT_W];
        w_out_valid_nxt = 1'b1;
        w_state_nxt     = S_HI;
      end
      S_HI: begin
        if (w_hs) begin
          w_out_data_nxt = r_hold;
          w_out_last_nxt = w_last_word;
          w_state_nxt    = S_LO;
        end
      end
      S_LO: begin
        if (w_hs) begin
          w_out_valid_nxt = 1'b0;
          w_out_last_nxt  = 1'b0;
          w_word_cnt_nxt  = r_word_cnt + 8'd1;
          if (w_last_word) begin
            w_state_nxt = S_IDLE;
          end else if (empty_ar) begin
            // Truncated burst: no out_last, flag sticks until reset.
            w_underrun_nxt = 1'b1;
            w_state_nxt    = S_IDLE;
          end else begin
            w_rdreq_nxt = 1'b1;
            w_state_nxt = S_RD;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_word_cnt  <= 8'd0;
      r_hold      <= '0;
      r_rdreq     <= 1'b0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_word_cnt  <= w_word_cnt_nxt;
      r_hold      <= w_hold_nxt;
      r_rdreq     <= w_rdreq_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_last  <= w_out_last_nxt;
      r_underrun  <= w_underrun_nxt;
    end
  end

  assign rdreq_ar    = r_rdreq;
  assign out_data    = r_out_data;
  assign out_valid   = r_out_valid;
  assign out_last    = r_out_last;
  assign underrun    = r_underrun;
  assign busy        = (r_state != S_IDLE);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ar_fifo_drain.sv
// Bench for ar_fifo_drain: depth-16 non-show-ahead FIFO model, word-level
// reference queue, expected-halfword scoreboard and a decoupled output monitor.
module tb_ar_fifo_drain;
  import ar_fifo_drain_pkg::*;

  localparam int BL    = AR_BURST_LEN;
  localparam int OW    = AR_OUT_W;
  localparam int DW    = AR_DATA_W;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          full_ar = 1'b0;
  logic          empty_ar = 1'b1;
  logic [DW-1:0] data_ar = '0;
  logic          rdreq_ar;
  logic          flush;
  logic [OW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          out_last;
  logic          busy;
  logic          underrun;
  logic [2:0]    dbg_state;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] mdl_q[$];
  logic [OW:0]   exp_q[$];

  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          fifo_clr = 1'b0;
  logic          refill = 1'b0;
  logic [DW-1:0] refill_val = 32'h0101_0202;
  logic          ready_rand = 1'b0;

  int n_cmp = 0;
  int n_fail = 0;
  int hs_cnt = 0;
  int rdreq_cnt = 0;

  logic          prev_stall = 1'b0;
  logic          prev_rdreq = 1'b0;
  logic [OW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;
  logic [OW:0]   mon_e;

  ar_fifo_drain dut (
    .clk        (clk),
    .reset      (reset),
    .full_ar    (full_ar),
    .empty_ar   (empty_ar),
    .data_ar    (data_ar),
    .rdreq_ar   (rdreq_ar),
    .flush      (flush),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .busy       (busy),
    .underrun   (underrun),
    .o_dbg_state(dbg_state)
  );

  // clock / reset
  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // FIFO model with registered flags; mdl_q logs every accepted word in order
  always @(posedge clk) begin
    if (fifo_clr) begin
      fifo_q.delete();
      mdl_q.delete();
    end else begin
      if (rdreq_ar && fifo_q.size() != 0) data_ar <= fifo_q.pop_front();
      if (wr_en && fifo_q.size() < DEPTH) begin
        fifo_q.push_back(wr_data);
        mdl_q.push_back(wr_data);
      end
      if (refill && fifo_q.size() < DEPTH) begin
        fifo_q.push_back(refill_val);
        mdl_q.push_back(refill_val);
        refill_val <= refill_val + 32'h0002_0002;
      end
    end
    full_ar  <= (fifo_q.size() == DEPTH);
    empty_ar <= (fifo_q.size() == 0);
  end

  // sink ready driver
  initial forever begin
    @(posedge clk);
    #1;
    out_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!reset) begin
      prev_stall = 1'b0;
      prev_rdreq = 1'b0;
    end else begin
      if (prev_stall)
        check("stall_hold", {out_valid, out_last, out_data}, {1'b1, prev_last, prev_data});
      if (out_valid && out_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_out: got %0h last %0b, nothing expected", out_data, out_last);
        end else begin
          mon_e = exp_q.pop_front();
          check("out_data", out_data, mon_e[OW-1:0]);
          check("out_last", out_last, mon_e[OW]);
        end
      end
      if (rdreq_ar) begin
        rdreq_cnt++;
        check("rdreq_while_empty", empty_ar, 0);
        check("rdreq_back_to_back", prev_rdreq, 0);
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
      prev_rdreq = rdreq_ar;
    end
  end

  // driver tasks
  task automatic write_words(input int n, input bit ramp);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      wr_en = 1'b1;
      if (ramp && i < 8) wr_data = {16'(2 * i + 1), 16'(2 * i + 2)};
      else               wr_data = $urandom;
    end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // A burst yields min(avail, BL) words; out_last only on a complete burst.
  task automatic expect_burst(input int avail);
    int n;
    logic [DW-1:0] w;
    n = (avail < BL) ? avail : BL;
    for (int i = 0; i < n; i++) begin
      if (mdl_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL model_underflow: got 0 words, expected %0d", n - i);
        return;
      end
      w = mdl_q.pop_front();
      exp_q.push_back({1'b0, w[DW-1:OW]});
      exp_q.push_back({(n == BL) && (i == n - 1), w[OW-1:0]});
    end
  endtask

  task automatic pulse_flush();
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic pulse_fifo_clr();
    @(negedge clk);
    fifo_clr = 1'b1;
    @(negedge clk);
    fifo_clr = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || busy) && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (k >= budget) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d halfwords pending, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"},  out_data, 0);
    check({tag, "_out_last"},  out_last, 0);
    check({tag, "_rdreq"},     rdreq_ar, 0);
    check({tag, "_busy"},      busy, 0);
    check({tag, "_underrun"},  underrun, 0);
    check({tag, "_state"},     dbg_state, ST_IDLE);
  endtask

  initial begin
    int base;
    int k;
    int g;
    logic busy_seen;

    reset = 1'b0;
    flush = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("rst");
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // full-triggered burst then flush drain, first with ready=1, then random ready
    for (int pass = 0; pass < 2; pass++) begin
      ready_rand = 1'(pass);
      base = rdreq_cnt;
      write_words(16, 1'b1);
      expect_burst(16);
      wait_drain(400);
      check("full_rdreq_count", rdreq_cnt - base, 8);
      check("full_underrun", underrun, 0);
      check("full_busy_low", busy, 0);
      base = rdreq_cnt;
      expect_burst(16);
      pulse_flush();
      wait_drain(400);
      check("flush8_rdreq_count", rdreq_cnt - base, 8);
      check("flush8_underrun", underrun, 0);
      check("flush8_fifo_empty", empty_ar, 1);
    end

    // empty FIFO with flush held: nothing happens
    base = rdreq_cnt;
    busy_seen = 1'b0;
    flush = 1'b1;
    repeat (20) begin
      @(negedge clk);
      busy_seen = busy_seen | busy;
    end
    flush = 1'b0;
    check("idle_rdreq_count", rdreq_cnt - base, 0);
    check("idle_busy_seen", busy_seen, 0);

    // three words then flush: truncated burst, sticky underrun
    ready_rand = 1'b1;
    base = rdreq_cnt;
    write_words(3, 1'b0);
    expect_burst(3);
    pulse_flush();
    wait_drain(200);
    check("trunc_rdreq_count", rdreq_cnt - base, 3);
    check("trunc_underrun", underrun, 1);
    check("trunc_busy_low", busy, 0);

    // FIFO held full by refilling writer: back-to-back bursts
    ready_rand = 1'b0;
    @(negedge clk);
    refill = 1'b1;
    k = 0;
    while (mdl_q.size() < 16 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("refill_filled", (mdl_q.size() >= 16), 1);
    expect_burst(BL);
    expect_burst(BL);
    k = 0;
    while (!busy && k < 50) begin @(negedge clk); k++; end
    k = 0;
    while (busy && k < 100) begin @(negedge clk); k++; end
    g = 0;
    while (!busy && g < 10) begin
      g++;
      @(negedge clk);
    end
    refill = 1'b0;
    check("burst_gap_cycles", g, 1);
    wait_drain(200);
    repeat (5) @(negedge clk);
    check("no_third_burst", busy, 0);
    pulse_fifo_clr();

    // reset during HI of word 4
    base = hs_cnt;
    write_words(16, 1'b0);
    expect_burst(16);
    k = 0;
    while ((hs_cnt - base) < 6 && k < 200) begin @(negedge clk); k++; end
    k = 0;
    while (dbg_state != ST_HI && k < 20) begin @(negedge clk); k++; end
    check("reached_word4_hi", dbg_state, ST_HI);
    #2;
    reset = 1'b0;
    #1;
    check_reset_values("midrst");
    exp_q.delete();
    pulse_fifo_clr();
    @(negedge clk);
    reset = 1'b1;
    base = rdreq_cnt;
    busy_seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      busy_seen = busy_seen | busy;
    end
    check("post_rst_rdreq_count", rdreq_cnt - base, 0);
    check("post_rst_busy_seen", busy_seen, 0);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
